// File: rtl/rab_miss_arbiter_if.sv
// rtl/rab_miss_arbiter_if.sv - miss-event inputs and miss-FIFO write port of the RAB miss arbiter
interface rab_miss_arbiter_if #(
    parameter int N_PORTS        = 3,
    parameter int C_AXI_ID_WIDTH = 8,
    parameter int PORT_ID_WIDTH  = (N_PORTS < 3) ? 1 : $clog2(N_PORTS)
);
    logic [N_PORTS-1:0]                     miss_valid;
    logic [N_PORTS-1:0][31:0]               miss_addr;
    logic [N_PORTS-1:0][C_AXI_ID_WIDTH-1:0] miss_id;
    logic [N_PORTS-1:0]                     miss_busy;
    logic                                   fifo_wvalid;
    logic                                   fifo_wready;
    logic [31:0]                            fifo_waddr;
    logic [PORT_ID_WIDTH+C_AXI_ID_WIDTH-1:0] fifo_wid;

    modport master (
        input  miss_valid, miss_addr, miss_id, fifo_wready,
        output miss_busy, fifo_wvalid, fifo_waddr, fifo_wid
    );

    modport slave (
        output miss_valid, miss_addr, miss_id, fifo_wready,
        input  miss_busy, fifo_wvalid, fifo_waddr, fifo_wid
    );
endinterface

// File: rtl/rab_miss_arbiter.sv
// rtl/rab_miss_arbiter.sv - per-port miss buffers, round-robin serialisation into the miss FIFO
module rab_miss_arbiter #(
    parameter int N_PORTS        = 3,
    parameter int C_AXI_ID_WIDTH = 8,
    parameter int PORT_ID_WIDTH  = (N_PORTS < 3) ? 1 : $clog2(N_PORTS),
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,
    rab_miss_arbiter_if.master        bus,
    input  logic                      drop_clr,
    output logic [N_PORTS-1:0]        drop_flag,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
    localparam int CNT_W = $clog2(N_PORTS + 1);
    localparam int SUM_W = DROP_CNT_WIDTH + CNT_W;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                                 state, state_next;
    logic [N_PORTS-1:0]                     pend;
    logic [N_PORTS-1:0][31:0]               pend_addr;
    logic [N_PORTS-1:0][C_AXI_ID_WIDTH-1:0] pend_id;
    logic [PORT_ID_WIDTH-1:0]               rr_ptr, rr_next, winner;
    logic                                   grant;
    logic [N_PORTS-1:0]                     grant_vec, drop_vec;
    logic [31:0]                            waddr;
    logic [PORT_ID_WIDTH+C_AXI_ID_WIDTH-1:0] wid;
    logic [CNT_W-1:0]                       ndrops;
    logic [SUM_W-1:0]                       drop_sum;
    logic [DROP_CNT_WIDTH-1:0]              drop_base, drop_cnt_next;
    int                                     idx;

    // First pending port at or after rr_ptr, wrapping modulo N_PORTS.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_PORTS;
            if (pend[idx]) begin
                winner = PORT_ID_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            EMPTY: begin
                if (|pend) begin
                    grant      = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (bus.fifo_wready) begin
                    if (|pend) begin
                        grant = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    assign grant_vec = grant ? (N_PORTS'(1) << winner) : '0;
    // A granted buffer frees this cycle, so a same-cycle miss on it is captured, not dropped.
    assign drop_vec  = bus.miss_valid & pend & ~grant_vec;
    assign rr_next   = (winner == PORT_ID_WIDTH'(N_PORTS - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        ndrops = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            ndrops = ndrops + CNT_W'(drop_vec[p]);
        end
        drop_base = drop_clr ? '0 : drop_cnt;
        drop_sum  = SUM_W'(drop_base) + SUM_W'(ndrops);
        if (|drop_sum[SUM_W-1:DROP_CNT_WIDTH]) begin
            drop_cnt_next = '1;
        end else begin
            drop_cnt_next = drop_sum[DROP_CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            pend      <= '0;
            pend_addr <= '0;
            pend_id   <= '0;
            rr_ptr    <= '0;
            waddr     <= '0;
            wid       <= '0;
            drop_flag <= '0;
            drop_cnt  <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (bus.miss_valid[p] && (!pend[p] || grant_vec[p])) begin
                    pend[p]      <= 1'b1;
                    pend_addr[p] <= bus.miss_addr[p];
                    pend_id[p]   <= bus.miss_id[p];
                end else if (grant_vec[p]) begin
                    pend[p] <= 1'b0;
                end
            end
            if (grant) begin
                waddr  <= pend_addr[winner];
                wid    <= {winner, pend_id[winner]};
                rr_ptr <= rr_next;
            end
            drop_flag <= (drop_clr ? '0 : drop_flag) | drop_vec;
            drop_cnt  <= drop_cnt_next;
        end
    end

    assign bus.miss_busy   = pend;
    assign bus.fifo_wvalid = (state == FULL);
    assign bus.fifo_waddr  = waddr;
    assign bus.fifo_wid    = wid;
endmodule
